id_fwd_stage: RTL and testbench

- Parametrised decode stage for the RV32I in-order pipeline. It merges instruction decode with the ID/EX pipeline register.
- Forwarding is generalised to NUM_FWD prioritised sources. Load-use hazards are detected and a bubble is inserted.
- It adds a valid/ready handshake to IF and EX, a branch flush, illegal-opcode flagging and a saturating stall counter.
- Sits between the IF/ID register and the EX stage; drives the regfile read ports.

---
 rtl/id_fwd_stage_pkg.sv | 44 ++++
 rtl/id_decoder.sv | 170 +++++++++++++++++
 rtl/id_fwd_stage.sv | 150 +++++++++++++++
 tb/tb_id_fwd_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_fwd_stage_pkg.sv
// Shared RV32I decode codes for the ID stage.
// Opcodes, instruction-type enum and the decode bundle.
package id_fwd_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int TYPE_W = 6;

  typedef enum logic [TYPE_W-1:0] {
    T_NOP, T_LUI, T_AUIPC, T_JAL, T_JALR,
    T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
    T_LB, T_LH, T_LW, T_LBU, T_LHU,
    T_SB, T_SH, T_SW,
    T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI,
    T_SLLI, T_SRLI, T_SRAI,
    T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU,
    T_XOR, T_SRL, T_SRA, T_OR, T_AND,
    T_FENCE, T_SYSTEM
  } inst_type_e;

  typedef struct packed {
    inst_type_e  typ;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_re;
    logic        rs2_re;
    logic        rd_we;
    logic        is_load;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder.
// Maps an instruction word to type, immediate and register use.
module id_decoder
  import id_fwd_stage_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;

  assign op     = inst[6:0];
  assign f3     = inst[14:12];
  assign alt    = inst[30];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  // Opcode dispatch, then illegal/x0 gating of side effects.
  always_comb begin
    dec         = '0;
    dec.typ     = T_NOP;
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = inst[11:7];
    dec.illegal = 1'b1;
    unique case (1'b1)
      op == OP_LUI: begin
        dec.typ     = T_LUI;
        dec.imm     = imm_u;
        dec.rd_we   = 1'b1;
        dec.illegal = 1'b0;
      end
      op == OP_AUIPC: begin
        dec.typ     = T_AUIPC;
        dec.imm     = imm_u;
        dec.rd_we   = 1'b1;
        dec.illegal = 1'b0;
      end
      op == OP_JAL: begin
        dec.typ     = T_JAL;
        dec.imm     = imm_j;
        dec.rd_we   = 1'b1;
        dec.illegal = 1'b0;
      end
      op == OP_JALR: begin
        dec.typ     = T_JALR;
        dec.imm     = imm_i;
        dec.rs1_re  = 1'b1;
        dec.rd_we   = 1'b1;
        dec.illegal = f3 != 3'b000;
      end
      op == OP_BRANCH: begin
        dec.imm     = imm_b;
        dec.rs1_re  = 1'b1;
        dec.rs2_re  = 1'b1;
        dec.illegal = 1'b0;
        unique case (f3)
          3'b000:  dec.typ = T_BEQ;
          3'b001:  dec.typ = T_BNE;
          3'b100:  dec.typ = T_BLT;
          3'b101:  dec.typ = T_BGE;
          3'b110:  dec.typ = T_BLTU;
          3'b111:  dec.typ = T_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      op == OP_LOAD: begin
        dec.imm     = imm_i;
        dec.rs1_re  = 1'b1;
        dec.rd_we   = 1'b1;
        dec.is_load = 1'b1;
        dec.illegal = 1'b0;
        unique case (f3)
          3'b000:  dec.typ = T_LB;
          3'b001:  dec.typ = T_LH;
          3'b010:  dec.typ = T_LW;
          3'b100:  dec.typ = T_LBU;
          3'b101:  dec.typ = T_LHU;
          default: dec.illegal = 1'b1;
        endcase
      end
      op == OP_STORE: begin
        dec.imm     = imm_s;
        dec.rs1_re  = 1'b1;
        dec.rs2_re  = 1'b1;
        dec.illegal = 1'b0;
        unique case (f3)
          3'b000:  dec.typ = T_SB;
          3'b001:  dec.typ = T_SH;
          3'b010:  dec.typ = T_SW;
          default: dec.illegal = 1'b1;
        endcase
      end
      op == OP_IMM: begin
        dec.imm     = imm_i;
        dec.rs1_re  = 1'b1;
        dec.rd_we   = 1'b1;
        dec.illegal = 1'b0;
        unique case (f3)
          3'b000: dec.typ = T_ADDI;
          3'b010: dec.typ = T_SLTI;
          3'b011: dec.typ = T_SLTIU;
          3'b100: dec.typ = T_XORI;
          3'b110: dec.typ = T_ORI;
          3'b111: dec.typ = T_ANDI;
          3'b001: begin
            dec.typ = T_SLLI;
            dec.imm = imm_sh;
          end
          default: begin
            dec.typ = alt ? T_SRAI : T_SRLI;
            dec.imm = imm_sh;
          end
        endcase
      end
      op == OP_REG: begin
        dec.rs1_re  = 1'b1;
        dec.rs2_re  = 1'b1;
        dec.rd_we   = 1'b1;
        dec.illegal = 1'b0;
        unique case (f3)
          3'b000:  dec.typ = alt ? T_SUB : T_ADD;
          3'b001:  dec.typ = T_SLL;
          3'b010:  dec.typ = T_SLT;
          3'b011:  dec.typ = T_SLTU;
          3'b100:  dec.typ = T_XOR;
          3'b101:  dec.typ = alt ? T_SRA : T_SRL;
          3'b110:  dec.typ = T_OR;
          default: dec.typ = T_AND;
        endcase
      end
      op == OP_FENCE: begin
        dec.typ     = T_FENCE;
        dec.illegal = f3 != 3'b000;
      end
      op == OP_SYSTEM: begin
        dec.typ     = T_SYSTEM;
        dec.imm     = imm_i;
        dec.illegal = f3 != 3'b000;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.illegal) begin
      dec.typ     = T_NOP;
      dec.imm     = '0;
      dec.rs1_re  = 1'b0;
      dec.rs2_re  = 1'b0;
      dec.rd_we   = 1'b0;
      dec.is_load = 1'b0;
    end
    if (dec.rd == 5'd0) dec.rd_we = 1'b0;
  end

endmodule

// File: rtl/id_fwd_stage.sv
// RV32I decode stage with ID/EX register.
// Prioritised forwarding, load-use stall, flush, handshakes.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_FWD     = 2,
  parameter int INST_TYPE_W = 6,
  parameter int STALL_CNT_W = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          if_valid_in,
  input  logic [XLEN-1:0]               if_pc_in,
  input  logic [31:0]                   if_inst_in,
  output logic                          id_ready_out,
  output logic [REG_ADDR_W-1:0]         rs1_addr_out,
  output logic [REG_ADDR_W-1:0]         rs2_addr_out,
  output logic                          rs1_read_out,
  output logic                          rs2_read_out,
  input  logic [XLEN-1:0]               rs1_data_in,
  input  logic [XLEN-1:0]               rs2_data_in,
  input  logic [NUM_FWD-1:0]            fwd_wreg_in,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_waddr_in,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_wdata_in,
  input  logic [NUM_FWD-1:0]            fwd_is_load_in,
  input  logic                          flush_in,
  input  logic                          ex_ready_in,
  output logic                          ex_valid_out,
  output logic [INST_TYPE_W-1:0]        inst_type_out,
  output logic [XLEN-1:0]               pc_out,
  output logic [XLEN-1:0]               imm_out,
  output logic [XLEN-1:0]               rs1_val_out,
  output logic [XLEN-1:0]               rs2_val_out,
  output logic                          rd_we_out,
  output logic [REG_ADDR_W-1:0]         rd_addr_out,
  output logic                          is_load_out,
  output logic                          illegal_out,
  output logic                          stall_req_out,
  output logic [STALL_CNT_W-1:0]        stall_cnt_out
);

  localparam logic [INST_TYPE_W-1:0] NOP_CODE =
    INST_TYPE_W'(T_NOP);

  dec_t dec;

  id_decoder u_dec (
    .inst (if_inst_in),
    .dec  (dec)
  );

  assign rs1_addr_out = REG_ADDR_W'(dec.rs1);
  assign rs2_addr_out = REG_ADDR_W'(dec.rs2);
  assign rs1_read_out = dec.rs1_re;
  assign rs2_read_out = dec.rs2_re;

  // Chains run from the oldest source down to index 0,
  // so the nearest matching producer wins.
  logic [NUM_FWD:0][XLEN-1:0] c1;
  logic [NUM_FWD:0][XLEN-1:0] c2;
  logic [NUM_FWD:0]           l1;
  logic [NUM_FWD:0]           l2;

  assign c1[NUM_FWD] = rs1_data_in;
  assign c2[NUM_FWD] = rs2_data_in;
  assign l1[NUM_FWD] = 1'b0;
  assign l2[NUM_FWD] = 1'b0;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    logic [REG_ADDR_W-1:0] wa;
    logic [XLEN-1:0]       wd;
    logic                  m1;
    logic                  m2;
    assign wa    = fwd_waddr_in[k*REG_ADDR_W +: REG_ADDR_W];
    assign wd    = fwd_wdata_in[k*XLEN +: XLEN];
    assign m1    = fwd_wreg_in[k] && (wa == rs1_addr_out);
    assign m2    = fwd_wreg_in[k] && (wa == rs2_addr_out);
    assign c1[k] = m1 ? wd : c1[k+1];
    assign c2[k] = m2 ? wd : c2[k+1];
    assign l1[k] = m1 ? fwd_is_load_in[k] : l1[k+1];
    assign l2[k] = m2 ? fwd_is_load_in[k] : l2[k+1];
  end

  logic            use1;
  logic            use2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            adv;

  assign use1    = dec.rs1_re && (rs1_addr_out != '0);
  assign use2    = dec.rs2_re && (rs2_addr_out != '0);
  assign rs1_val = use1 ? c1[0] : '0;
  assign rs2_val = use2 ? c2[0] : '0;

  assign stall_req_out = if_valid_in &&
                         ((use1 && l1[0]) || (use2 && l2[0]));

  assign adv          = rdy_in && (!ex_valid_out || ex_ready_in);
  assign id_ready_out = adv && !stall_req_out && !flush_in;

  // ID/EX register: flush or bubble clears control, load captures.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ex_valid_out  <= 1'b0;
      inst_type_out <= NOP_CODE;
      pc_out        <= '0;
      imm_out       <= '0;
      rs1_val_out   <= '0;
      rs2_val_out   <= '0;
      rd_we_out     <= 1'b0;
      rd_addr_out   <= '0;
      is_load_out   <= 1'b0;
      illegal_out   <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in ||
          (adv && (!if_valid_in || stall_req_out))) begin
        ex_valid_out  <= 1'b0;
        inst_type_out <= NOP_CODE;
        rd_we_out     <= 1'b0;
        is_load_out   <= 1'b0;
        illegal_out   <= 1'b0;
      end else if (adv) begin
        ex_valid_out  <= 1'b1;
        inst_type_out <= INST_TYPE_W'(dec.typ);
        pc_out        <= if_pc_in;
        imm_out       <= XLEN'($signed(dec.imm));
        rs1_val_out   <= rs1_val;
        rs2_val_out   <= rs2_val;
        rd_we_out     <= dec.rd_we;
        rd_addr_out   <= REG_ADDR_W'(dec.rd);
        is_load_out   <= dec.is_load;
        illegal_out   <= dec.illegal;
      end
    end
  end

  // Saturating count of stalled cycles; flush leaves it alone.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_cnt_out <= '0;
    end else if (rdy_in && stall_req_out &&
                 (stall_cnt_out != '1)) begin
      stall_cnt_out <= stall_cnt_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage.
// Hand-computed vectors checked with immediate assertions.
module tb_id_fwd_stage;
  import id_fwd_stage_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_valid_in;
  logic [31:0] if_pc_in;
  logic [31:0] if_inst_in;
  logic        id_ready_out;
  logic [4:0]  rs1_addr_out;
  logic [4:0]  rs2_addr_out;
  logic        rs1_read_out;
  logic        rs2_read_out;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic [1:0]  fwd_wreg_in;
  logic [9:0]  fwd_waddr_in;
  logic [63:0] fwd_wdata_in;
  logic [1:0]  fwd_is_load_in;
  logic        flush_in;
  logic        ex_ready_in;
  logic        ex_valid_out;
  logic [5:0]  inst_type_out;
  logic [31:0] pc_out;
  logic [31:0] imm_out;
  logic [31:0] rs1_val_out;
  logic [31:0] rs2_val_out;
  logic        rd_we_out;
  logic [4:0]  rd_addr_out;
  logic        is_load_out;
  logic        illegal_out;
  logic        stall_req_out;
  logic [15:0] stall_cnt_out;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk_in = ~clk_in;

  id_fwd_stage dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .if_valid_in    (if_valid_in),
    .if_pc_in       (if_pc_in),
    .if_inst_in     (if_inst_in),
    .id_ready_out   (id_ready_out),
    .rs1_addr_out   (rs1_addr_out),
    .rs2_addr_out   (rs2_addr_out),
    .rs1_read_out   (rs1_read_out),
    .rs2_read_out   (rs2_read_out),
    .rs1_data_in    (rs1_data_in),
    .rs2_data_in    (rs2_data_in),
    .fwd_wreg_in    (fwd_wreg_in),
    .fwd_waddr_in   (fwd_waddr_in),
    .fwd_wdata_in   (fwd_wdata_in),
    .fwd_is_load_in (fwd_is_load_in),
    .flush_in       (flush_in),
    .ex_ready_in    (ex_ready_in),
    .ex_valid_out   (ex_valid_out),
    .inst_type_out  (inst_type_out),
    .pc_out         (pc_out),
    .imm_out        (imm_out),
    .rs1_val_out    (rs1_val_out),
    .rs2_val_out    (rs2_val_out),
    .rd_we_out      (rd_we_out),
    .rd_addr_out    (rd_addr_out),
    .is_load_out    (is_load_out),
    .illegal_out    (illegal_out),
    .stall_req_out  (stall_req_out),
    .stall_cnt_out  (stall_cnt_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    if_valid_in    = 1'b0;
    if_pc_in       = '0;
    if_inst_in     = '0;
    rs1_data_in    = '0;
    rs2_data_in    = '0;
    fwd_wreg_in    = '0;
    fwd_waddr_in   = '0;
    fwd_wdata_in   = '0;
    fwd_is_load_in = '0;
    flush_in       = 1'b0;
    ex_ready_in    = 1'b1;

    tick();
    tick();
    chk("rst_valid", ex_valid_out, 0);
    chk("rst_type", inst_type_out, T_NOP);
    chk("rst_cnt", stall_cnt_out, 0);
    chk("rst_pc", pc_out, 0);
    rst_in = 1'b1;

    // add x3,x1,x2 with both sources writing x1
    if_valid_in  = 1'b1;
    if_pc_in     = 32'h100;
    if_inst_in   = 32'h002081B3;
    rs1_data_in  = 32'h33;
    rs2_data_in  = 32'h44;
    fwd_wreg_in  = 2'b11;
    fwd_waddr_in = {5'd1, 5'd1};
    fwd_wdata_in = {32'h22, 32'h11};
    #1;
    chk("add_rs1_addr", rs1_addr_out, 1);
    chk("add_rs2_addr", rs2_addr_out, 2);
    chk("add_rd_en", {rs1_read_out, rs2_read_out}, 2'b11);
    chk("add_ready", id_ready_out, 1);
    tick();
    chk("prio_src0", rs1_val_out, 32'h11);
    chk("prio_rs2_rf", rs2_val_out, 32'h44);
    chk("add_type", inst_type_out, T_ADD);
    chk("add_rd", {rd_we_out, rd_addr_out}, {1'b1, 5'd3});
    chk("add_pc", pc_out, 32'h100);
    chk("add_valid", ex_valid_out, 1);

    fwd_wreg_in = 2'b10;
    tick();
    chk("prio_src1", rs1_val_out, 32'h22);
    fwd_wreg_in = 2'b00;
    tick();
    chk("prio_rf", rs1_val_out, 32'h33);

    // addi x0,x0,5 with src0 writing x0
    if_inst_in   = 32'h00500013;
    fwd_wreg_in  = 2'b01;
    fwd_waddr_in = {5'd0, 5'd0};
    fwd_wdata_in = {32'h0, 32'hFF};
    tick();
    chk("x0_val", rs1_val_out, 0);
    chk("x0_we", rd_we_out, 0);
    chk("x0_imm", imm_out, 5);
    chk("x0_type", inst_type_out, T_ADDI);

    // lw x5,0(x0) then add x6,x5,x0 (load-use)
    if_inst_in  = 32'h00002283;
    fwd_wreg_in = 2'b00;
    tick();
    chk("lw_load", is_load_out, 1);
    chk("lw_type", inst_type_out, T_LW);
    chk("lw_rd", rd_addr_out, 5);
    if_inst_in     = 32'h00028333;
    fwd_wreg_in    = 2'b01;
    fwd_waddr_in   = {5'd0, 5'd5};
    fwd_wdata_in   = {32'h0, 32'hDEAD};
    fwd_is_load_in = 2'b01;
    #1;
    chk("lu_stall", stall_req_out, 1);
    chk("lu_ready", id_ready_out, 0);
    tick();
    chk("lu_bubble", ex_valid_out, 0);
    chk("lu_bub_type", inst_type_out, T_NOP);
    chk("lu_cnt", stall_cnt_out, 1);
    fwd_is_load_in = 2'b00;
    fwd_wdata_in   = {32'h0, 32'h5555};
    #1;
    chk("lu_nostall", stall_req_out, 0);
    tick();
    chk("lu_valid", ex_valid_out, 1);
    chk("lu_fwd", rs1_val_out, 32'h5555);
    chk("lu_rd", rd_addr_out, 6);
    chk("lu_cnt_hold", stall_cnt_out, 1);

    // backpressure with addi x7,x0,0x12 waiting
    ex_ready_in = 1'b0;
    if_inst_in  = 32'h01200393;
    fwd_wreg_in = 2'b00;
    #1;
    chk("bp_ready", id_ready_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_rd", rd_addr_out, 6);
      chk("bp_val", rs1_val_out, 32'h5555);
      chk("bp_valid", ex_valid_out, 1);
    end
    ex_ready_in = 1'b1;
    #1;
    chk("bp_rel_ready", id_ready_out, 1);
    tick();
    chk("bp_new_rd", rd_addr_out, 7);
    chk("bp_new_imm", imm_out, 32'h12);
    chk("bp_new_type", inst_type_out, T_ADDI);

    // flush with blt x1,x2,-8 incoming
    if_inst_in = 32'hFE20CCE3;
    if_pc_in   = 32'h180;
    flush_in   = 1'b1;
    #1;
    chk("fl_ready", id_ready_out, 0);
    tick();
    chk("fl_valid", ex_valid_out, 0);
    chk("fl_type", inst_type_out, T_NOP);
    flush_in = 1'b0;
    #1;
    chk("blt_rs", {rs1_addr_out, rs2_addr_out}, {5'd1, 5'd2});
    tick();
    chk("blt_type", inst_type_out, T_BLT);
    chk("blt_imm", imm_out, 32'hFFFFFFF8);
    chk("blt_we", rd_we_out, 0);
    chk("blt_valid", ex_valid_out, 1);

    // global freeze
    rdy_in     = 1'b0;
    if_inst_in = 32'h002081B3;
    if_pc_in   = 32'h200;
    #1;
    chk("frz_ready", id_ready_out, 0);
    tick();
    chk("frz_type", inst_type_out, T_BLT);
    chk("frz_pc", pc_out, 32'h180);
    rdy_in = 1'b1;
    tick();
    chk("unfrz_type", inst_type_out, T_ADD);
    chk("unfrz_pc", pc_out, 32'h200);
    chk("unfrz_val", rs1_val_out, 32'h33);

    // async reset between edges
    #3;
    rst_in = 1'b0;
    #1;
    chk("ar_valid", ex_valid_out, 0);
    chk("ar_pc", pc_out, 0);
    chk("ar_val", rs1_val_out, 0);
    chk("ar_type", inst_type_out, T_NOP);
    rst_in     = 1'b1;
    if_inst_in = 32'h0000007F;
    #1;
    chk("ill_rd_en", {rs1_read_out, rs2_read_out}, 2'b00);
    tick();
    chk("ill_flag", illegal_out, 1);
    chk("ill_type", inst_type_out, T_NOP);
    chk("ill_we", rd_we_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
